// File: rtl/lda_pkg.sv
// Shared types and constants for the queued line-drawing engine:
// command record, register map addresses, engine states and a small
// absolute-difference helper used when a line is loaded.
package lda_pkg;

  localparam int unsigned LDA_X_W      = 9;
  localparam int unsigned LDA_Y_W      = 8;
  localparam int unsigned LDA_COLOUR_W = 3;
  // Signed Bresenham error term: one bit of headroom plus a sign bit.
  localparam int unsigned LDA_ERR_W    = ((LDA_X_W > LDA_Y_W) ? LDA_X_W : LDA_Y_W) + 2;

  typedef struct packed {
    logic [LDA_X_W-1:0]      x0;
    logic [LDA_Y_W-1:0]      y0;
    logic [LDA_X_W-1:0]      x1;
    logic [LDA_Y_W-1:0]      y1;
    logic [LDA_COLOUR_W-1:0] colour;
  } lda_cmd_t;

  localparam logic [2:0] ADDR_STATUS   = 3'd0;
  localparam logic [2:0] ADDR_START    = 3'd1;
  localparam logic [2:0] ADDR_END      = 3'd2;
  localparam logic [2:0] ADDR_COLOUR   = 3'd3;
  localparam logic [2:0] ADDR_GO       = 3'd4;
  localparam logic [2:0] ADDR_MODE     = 3'd5;
  localparam logic [2:0] ADDR_PIXCOUNT = 3'd6;
  localparam logic [2:0] ADDR_RSVD     = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DRAW = 2'd2
  } lda_state_e;

  // |a - b| for zero-extended coordinates.
  function automatic logic [LDA_ERR_W-1:0] lda_abs_diff(input logic [LDA_ERR_W-1:0] a,
                                                         input logic [LDA_ERR_W-1:0] b);
    logic [LDA_ERR_W-1:0] diff_s;
    if (a >= b) begin
      diff_s = a - b;
    end else begin
      diff_s = b - a;
    end
    return diff_s;
  endfunction

endpackage

// File: rtl/lda_cmd_fifo.sv
// Synchronous command FIFO for queued line requests. Push is ignored when
// full and pop when empty, so the caller may drive them unconditionally.
module lda_cmd_fifo
  import lda_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  lda_cmd_t                 data_i,
  input  logic                     pop_i,
  output lda_cmd_t                 data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = AW + 1;

  lda_cmd_t             mem_q [DEPTH];
  logic [AW-1:0]        wr_ptr_q;
  logic [AW-1:0]        rd_ptr_q;
  logic [CNT_W-1:0]     count_q;
  logic                 do_push_s;
  logic                 do_pop_s;

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == {CNT_W{1'b0}});
  assign count_o   = count_q;
  assign data_o    = mem_q[rd_ptr_q];
  assign do_push_s = push_i && !full_o;
  assign do_pop_s  = pop_i && !empty_o;

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_q <= wr_ptr_q + AW'(1'b1);
      end
      if (do_pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1'b1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_q <= count_q + CNT_W'(1'b1);
        2'b01:   count_q <= count_q - CNT_W'(1'b1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage, cleared on reset so a flushed queue holds no stale lines.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= {$bits(lda_cmd_t){1'b0}};
      end
    end else if (do_push_s) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/lda_queued_engine.sv
// Queued line-drawing engine: Avalon-MM register file feeding a command
// FIFO, and a Bresenham FSM emitting one pixel per cycle on a valid/ready
// stream. Optional feature macro: LDA_CLIP_EN (skip pixels outside
// X_RES x Y_RES without emitting or counting them).
// Coordinate widths must match the lda_pkg values carried in lda_cmd_t.
module lda_queued_engine
  import lda_pkg::*;
#(
  parameter int unsigned X_W        = LDA_X_W,
  parameter int unsigned Y_W        = LDA_Y_W,
  parameter int unsigned COLOUR_W   = LDA_COLOUR_W,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned X_RES      = 320,
  parameter int unsigned Y_RES      = 240
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [2:0]          avs_s1_address,
  input  logic                avs_s1_read,
  input  logic                avs_s1_write,
  input  logic [31:0]         avs_s1_writedata,
  output logic [31:0]         avs_s1_readdata,
  output logic                avs_s1_waitrequest,
  output logic [X_W-1:0]      pix_x,
  output logic [Y_W-1:0]      pix_y,
  output logic [COLOUR_W-1:0] pix_colour,
  output logic                pix_valid,
  input  logic                pix_ready
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned XY_W  = X_W + Y_W;
  localparam int unsigned E_W   = LDA_ERR_W;

`ifdef LDA_CLIP_EN
  localparam logic CLIP_EN = 1'b1;
`else
  localparam logic CLIP_EN = 1'b0;
`endif

  // Register file
  logic [XY_W-1:0]     start_q;
  logic [XY_W-1:0]     end_q;
  logic [COLOUR_W-1:0] colour_q;
  logic                mode_q;
  logic                overflow_q;
  logic [31:0]         pixcount_q;

  // FIFO interface
  lda_cmd_t            fifo_din_s;
  lda_cmd_t            fifo_dout_s;
  logic                fifo_full_s;
  logic                fifo_empty_s;
  logic [CNT_W-1:0]    fifo_count_s;
  logic                fifo_pop_s;

  // Avalon decode
  logic                wr_go_s;
  logic                go_push_s;
  logic                go_drop_s;
  logic                busy_s;
  logic                pix_hs_s;
  logic [31:0]         rdata_s;

  // Engine state
  lda_state_e          state_q;
  lda_cmd_t            cmd_q;
  logic [X_W-1:0]      x_q;
  logic [Y_W-1:0]      y_q;
  logic [COLOUR_W-1:0] pix_colour_q;
  logic signed [E_W-1:0] dx_q;
  logic signed [E_W-1:0] dy_q;
  logic signed [E_W-1:0] err_q;
  logic                sx_q;
  logic                sy_q;
  logic                pix_valid_q;

  // Engine combinational helpers
  logic [E_W-1:0]        ld_dx_s;
  logic [E_W-1:0]        ld_dy_s;
  logic signed [E_W:0]   e2_s;
  logic signed [E_W:0]   dx_ext_s;
  logic signed [E_W:0]   neg_dy_s;
  logic                  step_x_s;
  logic                  step_y_s;
  logic signed [E_W-1:0] err_nxt_s;
  logic [X_W-1:0]        x_nxt_s;
  logic [Y_W-1:0]        y_nxt_s;
  logic                  at_end_s;
  logic                  advance_s;

  // True when the pixel is to be shown; always true without clipping.
  function automatic logic in_range(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    logic within_s;
    within_s = ({{(32-X_W){1'b0}}, x} < X_RES) && ({{(32-Y_W){1'b0}}, y} < Y_RES);
    return !CLIP_EN || within_s;
  endfunction

  assign wr_go_s            = avs_s1_write && (avs_s1_address == ADDR_GO);
  assign go_push_s          = wr_go_s && !fifo_full_s;
  assign go_drop_s          = wr_go_s && fifo_full_s && mode_q;
  assign avs_s1_waitrequest = wr_go_s && fifo_full_s && !mode_q;
  assign busy_s             = !fifo_empty_s || (state_q != ST_IDLE);
  assign pix_hs_s           = pix_valid_q && pix_ready;
  assign fifo_pop_s         = (state_q == ST_IDLE) && !fifo_empty_s;

  assign fifo_din_s.x0      = start_q[X_W-1:0];
  assign fifo_din_s.y0      = start_q[XY_W-1:X_W];
  assign fifo_din_s.x1      = end_q[X_W-1:0];
  assign fifo_din_s.y1      = end_q[XY_W-1:X_W];
  assign fifo_din_s.colour  = colour_q;

  lda_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (go_push_s),
    .data_i  (fifo_din_s),
    .pop_i   (fifo_pop_s),
    .data_o  (fifo_dout_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .count_o (fifo_count_s)
  );

  // Software-visible registers, sticky overflow and accepted-pixel counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_q    <= {XY_W{1'b0}};
      end_q      <= {XY_W{1'b0}};
      colour_q   <= {COLOUR_W{1'b0}};
      mode_q     <= 1'b0;
      overflow_q <= 1'b0;
      pixcount_q <= 32'd0;
    end else begin
      if (avs_s1_write) begin
        case (avs_s1_address)
          ADDR_START:  start_q  <= avs_s1_writedata[XY_W-1:0];
          ADDR_END:    end_q    <= avs_s1_writedata[XY_W-1:0];
          ADDR_COLOUR: colour_q <= avs_s1_writedata[COLOUR_W-1:0];
          ADDR_MODE:   mode_q   <= avs_s1_writedata[0];
          default:     ;
        endcase
      end
      if (avs_s1_write && (avs_s1_address == ADDR_STATUS)) begin
        overflow_q <= 1'b0;
      end else if (go_drop_s) begin
        overflow_q <= 1'b1;
      end
      if (avs_s1_write && (avs_s1_address == ADDR_PIXCOUNT)) begin
        pixcount_q <= 32'd0;
      end else if (pix_hs_s) begin
        pixcount_q <= pixcount_q + 32'd1;
      end
    end
  end

  // Zero-wait read mux; returns zero when no read is in progress.
  always_comb begin
    rdata_s = 32'd0;
    if (avs_s1_read) begin
      case (avs_s1_address)
        ADDR_STATUS:   rdata_s = {16'd0, {(8-CNT_W){1'b0}}, fifo_count_s,
                                  5'd0, overflow_q, fifo_full_s, busy_s};
        ADDR_START:    rdata_s = {{(32-XY_W){1'b0}}, start_q};
        ADDR_END:      rdata_s = {{(32-XY_W){1'b0}}, end_q};
        ADDR_COLOUR:   rdata_s = {{(32-COLOUR_W){1'b0}}, colour_q};
        ADDR_MODE:     rdata_s = {31'd0, mode_q};
        ADDR_PIXCOUNT: rdata_s = pixcount_q;
        ADDR_GO:       rdata_s = 32'd0;
        ADDR_RSVD:     rdata_s = 32'd0;
        default:       rdata_s = 32'd0;
      endcase
    end else begin
      rdata_s = 32'd0;
    end
  end

  assign avs_s1_readdata = rdata_s;

  // Line setup terms and the next Bresenham step from the current pixel.
  always_comb begin
    ld_dx_s   = lda_abs_diff({{(E_W-X_W){1'b0}}, cmd_q.x1}, {{(E_W-X_W){1'b0}}, cmd_q.x0});
    ld_dy_s   = lda_abs_diff({{(E_W-Y_W){1'b0}}, cmd_q.y1}, {{(E_W-Y_W){1'b0}}, cmd_q.y0});
    e2_s      = {err_q, 1'b0};
    dx_ext_s  = {1'b0, dx_q};
    neg_dy_s  = -$signed({1'b0, dy_q});
    step_x_s  = (e2_s >= neg_dy_s);
    step_y_s  = (e2_s <= dx_ext_s);
    err_nxt_s = err_q;
    x_nxt_s   = x_q;
    y_nxt_s   = y_q;
    if (step_x_s) begin
      err_nxt_s = err_nxt_s - dy_q;
      x_nxt_s   = sx_q ? (x_q - X_W'(1'b1)) : (x_q + X_W'(1'b1));
    end else begin
      x_nxt_s   = x_q;
    end
    if (step_y_s) begin
      err_nxt_s = err_nxt_s + dx_q;
      y_nxt_s   = sy_q ? (y_q - Y_W'(1'b1)) : (y_q + Y_W'(1'b1));
    end else begin
      y_nxt_s   = y_q;
    end
    at_end_s  = (x_q == cmd_q.x1) && (y_q == cmd_q.y1);
    // A hidden (clipped) pixel advances without waiting for the sink.
    advance_s = (state_q == ST_DRAW) && (!pix_valid_q || pix_ready);
  end

  // Engine FSM: pop a command, load the step terms, then walk the line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cmd_q        <= {$bits(lda_cmd_t){1'b0}};
      x_q          <= {X_W{1'b0}};
      y_q          <= {Y_W{1'b0}};
      pix_colour_q <= {COLOUR_W{1'b0}};
      dx_q         <= {E_W{1'b0}};
      dy_q         <= {E_W{1'b0}};
      err_q        <= {E_W{1'b0}};
      sx_q         <= 1'b0;
      sy_q         <= 1'b0;
      pix_valid_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty_s) begin
            cmd_q   <= fifo_dout_s;
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          x_q          <= cmd_q.x0;
          y_q          <= cmd_q.y0;
          pix_colour_q <= cmd_q.colour;
          dx_q         <= ld_dx_s;
          dy_q         <= ld_dy_s;
          sx_q         <= (cmd_q.x1 < cmd_q.x0);
          sy_q         <= (cmd_q.y1 < cmd_q.y0);
          err_q        <= ld_dx_s - ld_dy_s;
          pix_valid_q  <= in_range(cmd_q.x0, cmd_q.y0);
          state_q      <= ST_DRAW;
        end
        ST_DRAW: begin
          if (advance_s) begin
            if (at_end_s) begin
              pix_valid_q <= 1'b0;
              state_q     <= ST_IDLE;
            end else begin
              x_q         <= x_nxt_s;
              y_q         <= y_nxt_s;
              err_q       <= err_nxt_s;
              pix_valid_q <= in_range(x_nxt_s, y_nxt_s);
            end
          end
        end
        default: begin
          pix_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign pix_x      = x_q;
  assign pix_y      = y_q;
  assign pix_colour = pix_colour_q;
  assign pix_valid  = pix_valid_q;

endmodule

// File: tb/tb_lda_queued_engine.sv
// Self-checking bench for lda_queued_engine: a Bresenham reference model
// fills an expected-pixel queue at GO time; a stream monitor pops and
// compares every accepted pixel and checks hold-stability under stall.
module tb_lda_queued_engine;

  localparam int X_W = 9;
  localparam int Y_W = 8;
  localparam int C_W = 3;
`ifdef LDA_CLIP_EN
  localparam bit CLIP_ON = 1'b1;
`else
  localparam bit CLIP_ON = 1'b0;
`endif

  logic           clk;
  logic           reset_n;
  logic [2:0]     address;
  logic           read;
  logic           write;
  logic [31:0]    wdata;
  logic [31:0]    readdata;
  logic           waitrequest;
  logic [X_W-1:0] pix_x;
  logic [Y_W-1:0] pix_y;
  logic [C_W-1:0] pix_colour;
  logic           pix_valid;
  logic           pix_ready = 1'b1;

  typedef struct { int x; int y; int c; } pix_t;
  pix_t exp_q[$];
  int   hs_log[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   ready_mode = 1;   // 0 low, 1 high, 2 random
  int   last_wr_cyc = 0;

  lda_queued_engine dut (
    .clk                (clk),
    .reset              (reset_n),
    .avs_s1_address     (address),
    .avs_s1_read        (read),
    .avs_s1_write       (write),
    .avs_s1_writedata   (wdata),
    .avs_s1_readdata    (readdata),
    .avs_s1_waitrequest (waitrequest),
    .pix_x              (pix_x),
    .pix_y              (pix_y),
    .pix_colour         (pix_colour),
    .pix_valid          (pix_valid),
    .pix_ready          (pix_ready)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  // Stream monitor: drive ready, then score the handshake seen by the next edge.
  initial begin : monitor
    bit   stall_pend;
    logic [X_W-1:0] hx;
    logic [Y_W-1:0] hy;
    logic [C_W-1:0] hc;
    pix_t e;
    stall_pend = 1'b0;
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       pix_ready = 1'b0;
        1:       pix_ready = 1'b1;
        default: pix_ready = 1'($urandom_range(0, 1));
      endcase
      if (reset_n) begin
        if (stall_pend) begin
          total++;
          if (pix_valid !== 1'b1 || pix_x !== hx || pix_y !== hy || pix_colour !== hc) begin
            bad++;
            $display("FAIL hold: got v=%0b (%0d,%0d,%0d) want v=1 (%0d,%0d,%0d)",
                     pix_valid, pix_x, pix_y, pix_colour, hx, hy, hc);
          end
        end
        if (pix_valid === 1'b1 && pix_ready) begin
          hs_log.push_back(cyc);
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_pixel: got (%0d,%0d,%0d) want none", pix_x, pix_y, pix_colour);
          end else begin
            e = exp_q.pop_front();
            if (pix_x !== e.x[X_W-1:0] || pix_y !== e.y[Y_W-1:0] || pix_colour !== e.c[C_W-1:0]) begin
              bad++;
              $display("FAIL pixel: got (%0d,%0d,%0d) want (%0d,%0d,%0d)",
                       pix_x, pix_y, pix_colour, e.x, e.y, e.c);
            end
          end
        end
        stall_pend = (pix_valid === 1'b1) && !pix_ready;
        hx = pix_x; hy = pix_y; hc = pix_colour;
      end else begin
        stall_pend = 1'b0;
      end
    end
  end

  function automatic bit visible(int x, int y);
    return !CLIP_ON || (x < 320 && y < 240);
  endfunction

  // Reference line walk, pushing every visible pixel into the expected queue.
  task automatic model_line(input int x0, input int y0, input int x1, input int y1, input int c);
    int dx, dy, sx, sy, err, e2, x, y, guard;
    pix_t p;
    dx = (x1 > x0) ? x1 - x0 : x0 - x1;
    dy = (y1 > y0) ? y0 - y1 : y1 - y0;   // negative magnitude
    sx = (x0 < x1) ? 1 : -1;
    sy = (y0 < y1) ? 1 : -1;
    err = dx + dy;
    x = x0; y = y0; guard = 0;
    while (guard < 2000) begin
      if (visible(x, y)) begin
        p.x = x; p.y = y; p.c = c;
        exp_q.push_back(p);
      end
      if (x == x1 && y == y1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
      guard++;
    end
  endtask

  task automatic avs_write(input logic [2:0] a, input logic [31:0] d, output int waits);
    @(negedge clk);
    address = a; wdata = d; write = 1'b1; waits = 0;
    while (waitrequest === 1'b1 && waits < 2000) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 2000) begin
      total++; bad++;
      $display("FAIL write_timeout: got waits=%0d want <2000", waits);
    end
    @(posedge clk);
    #1;
    last_wr_cyc = cyc;
    write = 1'b0;
  endtask

  task automatic avs_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a; read = 1'b1;
    #1;
    d = readdata;
    read = 1'b0;
  endtask

  task automatic set_regs(input int x0, input int y0, input int x1, input int y1, input int c);
    int w;
    avs_write(3'd1, 32'(y0 * 512 + x0), w);
    avs_write(3'd2, 32'(y1 * 512 + x1), w);
    avs_write(3'd3, 32'(c), w);
  endtask

  task automatic go_line(input int x0, input int y0, input int x1, input int y1, input int c,
                         input bit drawn, output int waits);
    set_regs(x0, y0, x1, y1, c);
    if (drawn) model_line(x0, y0, x1, y1, c);
    avs_write(3'd4, 32'd0, waits);
  endtask

  task automatic check_reg(input string name, input logic [2:0] a, input logic [31:0] want);
    logic [31:0] d;
    avs_read(a, d);
    total++;
    if (d !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, d, want);
    end
  endtask

  task automatic wait_idle(input string name);
    logic [31:0] d;
    int n;
    n = 0;
    d = 32'd1;
    while (d[0] && n < 3000) begin
      avs_read(3'd0, d);
      n++;
    end
    repeat (3) @(negedge clk);
    total++;
    if (d[0] || exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_drain: got busy=%0b left=%0d want busy=0 left=0", name, d[0], exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; address = 3'd0; read = 1'b0; write = 1'b0; wdata = 32'd0;
    repeat (3) @(negedge clk);
    total++;
    if (pix_valid !== 1'b0 || waitrequest !== 1'b0 || readdata !== 32'd0 ||
        pix_x !== '0 || pix_y !== '0 || pix_colour !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got v=%0b w=%0b rd=%0h xy=(%0d,%0d) want all 0",
               pix_valid, waitrequest, readdata, pix_x, pix_y);
    end
    reset_n = 1'b1;
    for (int a = 0; a < 8; a++) check_reg("reset_reg", 3'(a), 32'd0);
  endtask

  task automatic test_registers();
    int w;
    avs_write(3'd1, 32'hFFFF_FFFF, w); check_reg("start_mask", 3'd1, 32'h0001_FFFF);
    avs_write(3'd2, 32'h0000_ABCD, w); check_reg("end_rw", 3'd2, 32'h0000_ABCD);
    avs_write(3'd3, 32'h0000_00FF, w); check_reg("colour_mask", 3'd3, 32'h0000_0007);
    avs_write(3'd5, 32'h0000_0003, w); check_reg("mode_set", 3'd5, 32'h0000_0001);
    avs_write(3'd5, 32'h0000_0000, w); check_reg("mode_clr", 3'd5, 32'h0000_0000);
    check_reg("go_reads_zero", 3'd4, 32'd0);
    avs_write(3'd7, 32'hFFFF_FFFF, w); check_reg("addr7_zero", 3'd7, 32'd0);
  endtask

  task automatic test_basic();
    int w, go_cyc;
    avs_write(3'd6, 32'd0, w);
    hs_log.delete();
    go_line(0, 0, 3, 0, 5, 1'b1, w);
    go_cyc = last_wr_cyc;
    wait_idle("basic");
    total++;
    if (hs_log.size() != 4) begin
      bad++; $display("FAIL basic_count: got %0d want 4", hs_log.size());
    end else begin
      total++;
      if (hs_log[0] - go_cyc != 2) begin
        bad++; $display("FAIL basic_latency: got %0d want 2", hs_log[0] - go_cyc);
      end
      for (int i = 1; i < 4; i++) begin
        total++;
        if (hs_log[i] - hs_log[i-1] != 1) begin
          bad++; $display("FAIL basic_rate: got %0d want 1", hs_log[i] - hs_log[i-1]);
        end
      end
    end
    check_reg("basic_pixcount", 3'd6, 32'd4);
  endtask

  task automatic test_diag_and_point();
    int w;
    hs_log.delete();
    go_line(2, 5, 0, 0, 3, 1'b1, w);
    wait_idle("diag");
    total++;
    if (hs_log.size() != 6) begin
      bad++; $display("FAIL diag_count: got %0d want 6", hs_log.size());
    end
    hs_log.delete();
    go_line(7, 7, 7, 7, 1, 1'b1, w);
    wait_idle("point");
    total++;
    if (hs_log.size() != 1) begin
      bad++; $display("FAIL point_count: got %0d want 1", hs_log.size());
    end
    check_reg("diag_pixcount", 3'd6, 32'd11);
  endtask

  task automatic test_random_ready();
    int w;
    hs_log.delete();
    ready_mode = 2;
    go_line(0, 0, 10, 4, 6, 1'b1, w);
    avs_write(3'd1, 32'h0001_FFFF, w);   // mid-line write must not disturb the line
    avs_write(3'd3, 32'h0000_0001, w);
    wait_idle("random");
    ready_mode = 1;
    total++;
    if (hs_log.size() != 11) begin
      bad++; $display("FAIL random_count: got %0d want 11", hs_log.size());
    end
  endtask

  task automatic test_back_to_back();
    int w;
    hs_log.delete();
    go_line(0, 0, 3, 0, 2, 1'b1, w);
    go_line(5, 1, 7, 1, 4, 1'b1, w);
    wait_idle("b2b");
    total++;
    if (hs_log.size() != 7) begin
      bad++; $display("FAIL b2b_count: got %0d want 7", hs_log.size());
    end else begin
      total++;
      if (hs_log[4] - hs_log[3] != 3) begin
        bad++; $display("FAIL b2b_gap: got %0d want 3", hs_log[4] - hs_log[3]);
      end
    end
  endtask

  task automatic test_stall_mode();
    int w, n;
    avs_write(3'd5, 32'd0, w);
    ready_mode = 0;
    for (int i = 0; i < 5; i++) begin
      go_line(i, 1, i + 1, 1, i, 1'b1, w);
      total++;
      if (w != 0) begin
        bad++; $display("FAIL stall_early_wait: got %0d want 0", w);
      end
    end
    set_regs(20, 2, 22, 2, 7);
    model_line(20, 2, 22, 2, 7);
    @(negedge clk);
    address = 3'd4; wdata = 32'd0; write = 1'b1;
    #1;
    total++;
    if (waitrequest !== 1'b1) begin
      bad++; $display("FAIL stall_wait_on: got %0b want 1", waitrequest);
    end
    repeat (4) @(negedge clk);
    total++;
    if (waitrequest !== 1'b1) begin
      bad++; $display("FAIL stall_wait_hold: got %0b want 1", waitrequest);
    end
    ready_mode = 1;
    n = 0;
    while (waitrequest === 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 200) begin
      bad++; $display("FAIL stall_release: got waitrequest=1 want 0");
    end
    @(posedge clk);
    #1;
    write = 1'b0;
    wait_idle("stall");
  endtask

  task automatic test_poll_mode();
    int w;
    avs_write(3'd5, 32'd1, w);
    ready_mode = 0;
    for (int i = 0; i < 5; i++) go_line(30 + i, 3, 31 + i, 3, i, 1'b1, w);
    go_line(100, 50, 104, 52, 6, 1'b0, w);
    total++;
    if (w != 0) begin
      bad++; $display("FAIL poll_no_wait: got %0d want 0", w);
    end
    check_reg("poll_status_full", 3'd0, 32'h0000_0407);
    ready_mode = 1;
    wait_idle("poll");
    repeat (20) @(negedge clk);
    check_reg("poll_overflow_sticky", 3'd0, 32'h0000_0004);
    avs_write(3'd0, 32'd0, w);
    check_reg("poll_overflow_clear", 3'd0, 32'h0000_0000);
    avs_write(3'd5, 32'd0, w);
  endtask

  task automatic test_reset_midline();
    int w, n;
    ready_mode = 1;
    hs_log.delete();
    go_line(0, 0, 9, 0, 7, 1'b1, w);
    n = 0;
    while (hs_log.size() < 2 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    #1;
    reset_n = 1'b0;
    #1;
    total++;
    if (pix_valid !== 1'b0 || n >= 100) begin
      bad++; $display("FAIL reset_async: got v=%0b want 0", pix_valid);
    end
    exp_q.delete();
    check_reg("reset_status_in", 3'd0, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    check_reg("reset_status_out", 3'd0, 32'd0);
    check_reg("reset_pixcount", 3'd6, 32'd0);
    repeat (30) @(negedge clk);
    total++;
    if (hs_log.size() != 2) begin
      bad++; $display("FAIL reset_no_resume: got %0d want 2", hs_log.size());
    end
  endtask

  task automatic test_clip();
    int w, want;
    want = CLIP_ON ? 2 : 4;
    avs_write(3'd6, 32'd0, w);
    hs_log.delete();
    go_line(318, 0, 321, 0, 2, 1'b1, w);
    wait_idle("clip");
    total++;
    if (hs_log.size() != want) begin
      bad++; $display("FAIL clip_count: got %0d want %0d", hs_log.size(), want);
    end
    check_reg("clip_pixcount", 3'd6, 32'(want));
  endtask

  initial begin
    test_reset();
    test_registers();
    test_basic();
    test_diag_and_point();
    test_random_ready();
    test_back_to_back();
    test_stall_mode();
    test_poll_mode();
    test_reset_midline();
    test_clip();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lda_queued_engine.md
# lda_queued_engine

Parametrised successor to the single-shot LDA peripheral: an Avalon-MM slave with a command FIFO that queues line requests, feeding a Bresenham line engine. The engine emits one pixel per cycle onto a valid/ready pixel stream towards the VGA/framebuffer adapter. Software can post several lines back-to-back without polling for done. Adds stall/poll write modes and a pixel counter.

## Interface
- X_W, 9: x coordinate width
- Y_W, 8: y coordinate width
- COLOUR_W, 3: colour width
- FIFO_DEPTH, 4: queued commands; power of two, ≥2
- X_RES, 320 / Y_RES, 240: visible area (used only with clipping)
- clk  in  1  system clock, 50 MHz; single clock domain
- reset  in  1  asynchronous, active-low reset
- avs_s1_address  in  3  register select
- avs_s1_read / avs_s1_write  in  1  Avalon strobes
- avs_s1_writedata  in  32  write data
- avs_s1_readdata  out  32  read data, combinational, zero wait
- avs_s1_waitrequest  out  1  stall (GO write only)
- pix_x  out  X_W,  pix_y  out  Y_W,  pix_colour  out  COLOUR_W  pixel
- pix_valid  out  1  pixel present;  pix_ready  in  1  sink accepts

## Operation
- Register map (word addresses):
  - 0 STATUS (R): [0] busy, [1] fifo_full, [2] overflow (sticky), [15:8] fifo count. W: any write clears overflow.
  - 1 START (R/W): x0 = [X_W-1:0], y0 = [X_W+Y_W-1:X_W].
  - 2 END (R/W): x1/y1, same packing.
  - 3 COLOUR (R/W): [COLOUR_W-1:0].
  - 4 GO (W): pushes {START, END, COLOUR} into FIFO; reads return 0.
  - 5 MODE (R/W): [0] 0 = stall, 1 = poll.
  - 6 PIXCOUNT (R): 32-bit count of accepted pixels, wraps at 2^32. W: clears.
  - 7: reads 0, writes ignored.
- GO while FIFO full: stall mode holds waitrequest high until a slot frees, then accepts; poll mode drops the command and sets overflow. No same-cycle push-through on a pop.
- busy = FIFO non-empty or engine not IDLE.
- Engine FSM:
  - IDLE: pop on non-empty → LOAD.
  - LOAD: compute dx = |x1-x0|, dy = |y1-y0|, step signs, err = dx-dy → DRAW.
  - DRAW: present the pixel. On handshake, if the pixel is at (x1,y1) → IDLE, else take a Bresenham step.
- Pixels are emitted start to end, both endpoints included; count = max(dx,dy)+1. Error register is signed, max(X_W,Y_W)+2 bits.
- pix_* held stable while pix_valid && !pix_ready.
- Register writes during drawing affect only future GO pushes.

## Timing
- Reset values: readdata 0, waitrequest 0, pix_valid 0, pix_x/y/colour 0, MODE 0, START/END/COLOUR 0, PIXCOUNT 0, FIFO empty, FSM IDLE.
- GO accepted at edge N (FIFO empty, engine IDLE): pop at N+1, LOAD completes at N+2, pix_valid high after edge N+2.
- Throughput: 1 pixel/cycle with pix_ready high. Exactly one IDLE+LOAD gap (2 cycles) between consecutive lines.
- Reset asserted mid-line: pix_valid drops immediately (async), FIFO flushed, no partial resume.

## Configuration
- LDA_CLIP_EN defined: pixels with x ≥ X_RES or y ≥ Y_RES are stepped over internally in one cycle with pix_valid low, and not counted in PIXCOUNT.
- Undefined: every computed pixel is emitted and counted; X_RES/Y_RES unused.

## Structure
- lda_pkg: lda_cmd_t struct {x0,y0,x1,y1,colour} (width-parametrised via package parameters), register address localparams, engine state enum.
- Sub-module lda_cmd_fifo: synchronous FIFO of lda_cmd_t, FIFO_DEPTH entries, full/empty/count outputs. The top holds the register file, the Avalon decode and the Bresenham FSM.

## Test plan
- (0,0)→(3,0), colour 5, ready=1 → pixels (0,0),(1,0),(2,0),(3,0) on 4 consecutive cycles, first 2 cycles after the GO edge; PIXCOUNT=4.
- (2,5)→(0,0) → 6 pixels, first (2,5), last (0,0); each step |Δy|=1, |Δx|≤1. (7,7)→(7,7) → exactly one pixel.
- pix_ready random 50% on (0,0)→(10,4) → 11 pixels, held stable while stalled, no drops or duplicates.
- Stall mode, pix_ready=0, FIFO_DEPTH+2 GO writes → write FIFO_DEPTH+2 sees waitrequest until ready=1 frees a slot. Poll mode, same stimulus → overflow=1, extra command never drawn.
- Reset asserted during 3rd pixel of (0,0)→(9,0) → pix_valid 0 at once, STATUS=0, PIXCOUNT=0 after release.
- LDA_CLIP_EN, X_RES=320: (318,0)→(321,0) → only (318,0),(319,0) emitted; PIXCOUNT=2.
